// File: rtl/qos_fsm_pkg.sv
// QoS control FSM shared definitions: state encodings and state width.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package qos_fsm_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_e;

    // True in the two operational states where traffic-related inputs are honoured.
    function automatic logic is_run(input state_e s);
        return (s == ST_IDLE) || (s == ST_ACTIVE);
    endfunction

endpackage

// File: rtl/qos_pause_mask.sv
// Per-channel pause status register: set by pause, cleared by cont, pause wins on conflict.
// Latency: one cycle from sampled pause/cont/clr to mask.
// Backpressure: none; holds value whenever upd and clr are both low.
module qos_pause_mask #(
    parameter int NUM_CH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              upd,
    input  logic              clr,
    input  logic [NUM_CH-1:0] pause,
    input  logic [NUM_CH-1:0] cont,
    output logic [NUM_CH-1:0] mask
);

    // Per-channel set/clear; clr has priority over updates, no update means freeze.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask <= '0;
        end else if (clr) begin
            mask <= '0;
        end else if (upd) begin
            mask <= (mask & ~cont) | pause;
        end
    end

endmodule

// File: rtl/qos_fsm_n.sv
// QoS channel control FSM (RESET/INIT/IDLE/ACTIVE/ERROR) with thresholds, pause mask and sticky errors.
// Latency: every output registered, one cycle after the causing input; reset clears asynchronously.
// Backpressure: none; optional stall watchdog (QOS_FSM_WDOG_EN) forces ERROR after WDOG_LIMIT stalled cycles.
module qos_fsm_n
    import qos_fsm_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int TH_W       = 4,
    parameter int WDOG_LIMIT = 8
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               set_init,
    input  logic [TH_W-1:0]    th_hi_in,
    input  logic [TH_W-1:0]    th_lo_in,
    input  logic [NUM_CH-1:0]  empty,
    input  logic [NUM_CH-1:0]  full,
    input  logic [NUM_CH-1:0]  Pause,
    input  logic [NUM_CH-1:0]  Continue,
    output logic [STATE_W-1:0] state,
    output logic               idle_out,
`ifdef QOS_FSM_WDOG_EN
    output logic               wdog_err,
`endif
    output logic [NUM_CH-1:0]  error_out,
    output logic [NUM_CH-1:0]  pause_mask,
    output logic [TH_W-1:0]    th_hi,
    output logic [TH_W-1:0]    th_lo
);

    state_e state_q;
    state_e state_d;
    logic   full_err;
    logic   wdog_hit;

    // A full channel seen while operational is what makes error_out pick up new bits.
    assign full_err = is_run(state_q) && (|full);

`ifdef QOS_FSM_WDOG_EN
    localparam int CNT_W = (WDOG_LIMIT > 1) ? $clog2(WDOG_LIMIT) : 1;

    logic [CNT_W-1:0] wdog_cnt;
    logic             stall;

    // Stalled: active, at least one channel has data, and every such channel is paused.
    assign stall    = (state_q == ST_ACTIVE) && (|(~empty)) && ((~empty & ~pause_mask) == '0);
    assign wdog_hit = stall && (wdog_cnt == CNT_W'(WDOG_LIMIT - 1));

    // Consecutive-stall counter; any unstalled cycle or leaving ACTIVE restarts it.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            wdog_cnt <= '0;
        end else if (stall && (state_d == ST_ACTIVE)) begin
            wdog_cnt <= wdog_cnt + CNT_W'(1);
        end else begin
            wdog_cnt <= '0;
        end
    end

    // Sticky watchdog flag, cleared only by reset.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            wdog_err <= 1'b0;
        end else if (wdog_hit) begin
            wdog_err <= 1'b1;
        end
    end
`else
    logic unused_wdog_limit;

    assign wdog_hit          = 1'b0;
    assign unused_wdog_limit = ^WDOG_LIMIT;
`endif

    // Next-state selection; full beats watchdog beats set_init beats the empty vector.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET: state_d = ST_INIT;
            ST_INIT: begin
                if (!set_init) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE, ST_ACTIVE: begin
                if (|full) begin
                    state_d = ST_ERROR;
                end else if (wdog_hit) begin
                    state_d = ST_ERROR;
                end else if (set_init) begin
                    state_d = ST_INIT;
                end else if (!(&empty)) begin
                    state_d = ST_ACTIVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_RESET;
        endcase
    end

    // State register plus registered idle indication aligned with it.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q  <= ST_RESET;
            idle_out <= 1'b0;
        end else begin
            state_q  <= state_d;
            idle_out <= (state_d == ST_IDLE);
        end
    end

    // Thresholds track the inputs only while INIT is being requested.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            th_hi <= '0;
            th_lo <= '0;
        end else if ((state_q == ST_INIT) && set_init) begin
            th_hi <= th_hi_in;
            th_lo <= th_lo_in;
        end
    end

    // Error flags accumulate the full vector on entry to ERROR and stick until reset.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            error_out <= '0;
        end else if (full_err) begin
            error_out <= error_out | full;
        end
    end

    assign state = state_q;

    // Mask updates only when operational; RESET/INIT clear it and ERROR freezes it.
    qos_pause_mask #(
        .NUM_CH (NUM_CH)
    ) u_pause_mask (
        .clk   (CLK),
        .rst   (reset),
        .upd   (is_run(state_q)),
        .clr   ((state_q == ST_RESET) || (state_q == ST_INIT)),
        .pause (Pause),
        .cont  (Continue),
        .mask  (pause_mask)
    );

endmodule
